phase_mem_router: RTL and testbench

Parametrised successor to the histogram equalizer's memory controller. It multiplexes NUM_PHASES compute phases (histogram, cdf, divider, and further phases) onto one input memory, one scratch memory and one output memory. It also tracks input-memory read progress and checks write bounds, raising sticky overflow faults. It sits between top_level_control, the equalizer core and the memory macros.

---
 rtl/ph_mem_pkg.sv | 25 ++
 rtl/ph_wr_port.sv | 54 +++++
 rtl/phase_mem_router.sv | 192 +++++++++++++++++++
 tb/tb_phase_mem_router.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ph_mem_pkg.sv
// Shared state encoding, phase indices and owner-select helper for the
// phase memory router.
package ph_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        SWITCH = 2'd2
    } ph_state_e;

    localparam int PH_HIST = 0;
    localparam int PH_CDF  = 1;
    localparam int PH_DIV  = 2;

    // Lowest set bit wins, so a malformed multi-hot select still picks one owner.
    function automatic int unsigned onehot_to_idx(input logic [31:0] vec);
        int unsigned idx;
        idx = 0;
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/ph_wr_port.sv
// Registered write port: takes the owning phase's write one cycle late and
// drops writes beyond the latched memory depth, raising a sticky fault.
module ph_wr_port #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 128,
    parameter int DEPTH_W = 17
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_clear,
    input  logic               i_capture,
    input  logic               i_we,
    input  logic [ADDR_W-1:0]  i_waddr,
    input  logic [DATA_W-1:0]  i_wdata,
    input  logic [DEPTH_W-1:0] i_depth,
    output logic               o_we,
    output logic [ADDR_W-1:0]  o_waddr,
    output logic [DATA_W-1:0]  o_wdata,
    output logic               o_fault
);

    logic              w_req;
    logic              w_in_bounds;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_fault;

    assign w_req       = i_capture & i_we;
    assign w_in_bounds = DEPTH_W'(i_waddr) < i_depth;

    // Clear takes precedence over a fault raised in the same cycle.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_fault <= 1'b0;
        end else begin
            r_we <= w_req & w_in_bounds;
            if (w_req) begin
                r_waddr <= i_waddr;
                r_wdata <= i_wdata;
            end
            r_fault <= i_clear ? 1'b0 : (r_fault | (w_req & ~w_in_bounds));
        end
    end

    assign o_we    = r_we;
    assign o_waddr = r_waddr;
    assign o_wdata = r_wdata;
    assign o_fault = r_fault;

endmodule

// File: rtl/phase_mem_router.sv
// Multiplexes NUM_PHASES compute phases onto the input, scratch and output
// memories, tracking input read progress and write-bound faults.
module phase_mem_router
    import ph_mem_pkg::*;
#(
    parameter int NUM_PHASES = 3,
    parameter int DATA_W     = 128,
    parameter int ADDR_W     = 16,
    parameter int DEPTH_W    = 17
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_PHASES-1:0]        phase_en,
    input  logic                         image_done_pulse,
    input  logic [DEPTH_W-1:0]           input_mem_depth,
    input  logic [DEPTH_W-1:0]           scratch_mem_depth,
    input  logic [DEPTH_W-1:0]           output_mem_depth,
    input  logic [NUM_PHASES-1:0]        ph_in_rd_en,
    input  logic [NUM_PHASES*ADDR_W-1:0] ph_in_raddr0,
    input  logic [NUM_PHASES*ADDR_W-1:0] ph_in_raddr1,
    input  logic [NUM_PHASES*ADDR_W-1:0] ph_sc_raddr0,
    input  logic [NUM_PHASES*ADDR_W-1:0] ph_sc_raddr1,
    input  logic [NUM_PHASES-1:0]        ph_sc_WE,
    input  logic [NUM_PHASES*ADDR_W-1:0] ph_sc_waddr,
    input  logic [NUM_PHASES*DATA_W-1:0] ph_sc_wdata,
    input  logic [NUM_PHASES-1:0]        ph_out_WE,
    input  logic [NUM_PHASES*ADDR_W-1:0] ph_out_waddr,
    input  logic [NUM_PHASES*DATA_W-1:0] ph_out_wdata,
    output logic [DATA_W-1:0]            ph_in_rdata0,
    output logic [DATA_W-1:0]            ph_in_rdata1,
    output logic [DATA_W-1:0]            ph_sc_rdata0,
    output logic [DATA_W-1:0]            ph_sc_rdata1,
    output logic [NUM_PHASES-1:0]        ph_rdata_valid,
    output logic [ADDR_W-1:0]            final_input_mem_raddr0,
    output logic [ADDR_W-1:0]            final_input_mem_raddr1,
    output logic [ADDR_W-1:0]            final_scratch_mem_raddr0,
    output logic [ADDR_W-1:0]            final_scratch_mem_raddr1,
    input  logic [DATA_W-1:0]            final_input_mem_rdata0,
    input  logic [DATA_W-1:0]            final_input_mem_rdata1,
    input  logic [DATA_W-1:0]            final_scratch_mem_rdata0,
    input  logic [DATA_W-1:0]            final_scratch_mem_rdata1,
    output logic                         final_scratch_mem_WE,
    output logic [ADDR_W-1:0]            final_scratch_mem_waddr,
    output logic [DATA_W-1:0]            final_scratch_mem_wdata,
    output logic                         final_output_mem_WE,
    output logic [ADDR_W-1:0]            final_output_mem_waddr,
    output logic [DATA_W-1:0]            final_output_mem_wdata,
    output logic                         input_mem_done,
    output logic                         scratch_mem_overflow_fault,
    output logic                         output_mem_overflow_fault,
    output logic                         phase_sel_fault
);

    localparam int OWN_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
    localparam logic [DEPTH_W:0] CNT_MAX  = '1;
    localparam logic [DEPTH_W:0] CNT_STEP = (DEPTH_W+1)'(2);

    ph_state_e             r_state;
    logic [OWN_W-1:0]      r_owner;
    logic [DEPTH_W-1:0]    r_in_depth;
    logic [DEPTH_W-1:0]    r_sc_depth;
    logic [DEPTH_W-1:0]    r_out_depth;
    logic [DEPTH_W:0]      r_rd_cnt;
    logic                  r_in_done;
    logic                  r_sel_fault;
    logic [NUM_PHASES-1:0] r_rdata_valid;

    logic                  w_any_en;
    logic                  w_multi_en;
    logic [OWN_W-1:0]      w_sel_idx;
    logic                  w_active;
    logic                  w_rd_hit;
    logic [DEPTH_W:0]      w_cnt_next;
    logic [NUM_PHASES-1:0] w_owner_oh;

    assign w_any_en   = |phase_en;
    assign w_multi_en = (phase_en & (phase_en - NUM_PHASES'(1))) != '0;
    assign w_sel_idx  = OWN_W'(onehot_to_idx(32'(phase_en)));
    assign w_active   = (r_state == ACTIVE);
    assign w_owner_oh = NUM_PHASES'(1) << r_owner;
    assign w_rd_hit   = w_active & ph_in_rd_en[r_owner];

    always_comb begin
        w_cnt_next = r_rd_cnt;
        if (w_rd_hit) begin
            w_cnt_next = (r_rd_cnt > CNT_MAX - CNT_STEP) ? CNT_MAX : r_rd_cnt + CNT_STEP;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_owner <= OWN_W'(PH_HIST);
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_en) begin
                        r_state <= ACTIVE;
                        r_owner <= w_sel_idx;
                    end
                end
                ACTIVE: begin
                    if (!w_any_en)                 r_state <= IDLE;
                    else if (w_sel_idx != r_owner) r_state <= SWITCH;
                end
                SWITCH: begin
                    if (!w_any_en) begin
                        r_state <= IDLE;
                    end else begin
                        r_state <= ACTIVE;
                        r_owner <= w_sel_idx;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Depths track the inputs only while no phase owns the memories.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_in_depth    <= '0;
            r_sc_depth    <= '0;
            r_out_depth   <= '0;
            r_rd_cnt      <= '0;
            r_in_done     <= 1'b0;
            r_sel_fault   <= 1'b0;
            r_rdata_valid <= '0;
        end else begin
            if (r_state == IDLE) begin
                r_in_depth  <= input_mem_depth;
                r_sc_depth  <= scratch_mem_depth;
                r_out_depth <= output_mem_depth;
            end
            r_rdata_valid <= w_active ? w_owner_oh : '0;
            if (image_done_pulse) begin
                r_rd_cnt    <= '0;
                r_in_done   <= 1'b0;
                r_sel_fault <= 1'b0;
            end else begin
                r_rd_cnt    <= w_cnt_next;
                r_in_done   <= r_in_done | (w_active & (w_cnt_next >= {1'b0, r_in_depth}));
                r_sel_fault <= r_sel_fault | w_multi_en;
            end
        end
    end

    assign final_input_mem_raddr0   = w_active ? ph_in_raddr0[r_owner*ADDR_W +: ADDR_W] : '0;
    assign final_input_mem_raddr1   = w_active ? ph_in_raddr1[r_owner*ADDR_W +: ADDR_W] : '0;
    assign final_scratch_mem_raddr0 = w_active ? ph_sc_raddr0[r_owner*ADDR_W +: ADDR_W] : '0;
    assign final_scratch_mem_raddr1 = w_active ? ph_sc_raddr1[r_owner*ADDR_W +: ADDR_W] : '0;

    assign ph_in_rdata0   = final_input_mem_rdata0;
    assign ph_in_rdata1   = final_input_mem_rdata1;
    assign ph_sc_rdata0   = final_scratch_mem_rdata0;
    assign ph_sc_rdata1   = final_scratch_mem_rdata1;
    assign ph_rdata_valid = r_rdata_valid;

    ph_wr_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH_W(DEPTH_W)) u_sc_port (
        .i_clock   (clock),
        .i_reset   (reset),
        .i_clear   (image_done_pulse),
        .i_capture (w_active),
        .i_we      (ph_sc_WE[r_owner]),
        .i_waddr   (ph_sc_waddr[r_owner*ADDR_W +: ADDR_W]),
        .i_wdata   (ph_sc_wdata[r_owner*DATA_W +: DATA_W]),
        .i_depth   (r_sc_depth),
        .o_we      (final_scratch_mem_WE),
        .o_waddr   (final_scratch_mem_waddr),
        .o_wdata   (final_scratch_mem_wdata),
        .o_fault   (scratch_mem_overflow_fault)
    );

    ph_wr_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH_W(DEPTH_W)) u_out_port (
        .i_clock   (clock),
        .i_reset   (reset),
        .i_clear   (image_done_pulse),
        .i_capture (w_active),
        .i_we      (ph_out_WE[r_owner]),
        .i_waddr   (ph_out_waddr[r_owner*ADDR_W +: ADDR_W]),
        .i_wdata   (ph_out_wdata[r_owner*DATA_W +: DATA_W]),
        .i_depth   (r_out_depth),
        .o_we      (final_output_mem_WE),
        .o_waddr   (final_output_mem_waddr),
        .o_wdata   (final_output_mem_wdata),
        .o_fault   (output_mem_overflow_fault)
    );

    assign input_mem_done  = r_in_done;
    assign phase_sel_fault = r_sel_fault;

endmodule

// File: tb/tb_phase_mem_router.sv
// Directed bench for phase_mem_router with a cycle-level reference model.
module tb_phase_mem_router;

    localparam int NP   = 3;
    localparam int AW   = 16;
    localparam int DW   = 32;
    localparam int DPW  = 17;
    localparam int CMAX = (1 << (DPW + 1)) - 1;

    logic             clock = 1'b0;
    logic             reset;
    logic [NP-1:0]    phase_en;
    logic             image_done_pulse;
    logic [DPW-1:0]   input_mem_depth, scratch_mem_depth, output_mem_depth;
    logic [NP-1:0]    ph_in_rd_en;
    logic [NP*AW-1:0] ph_in_raddr0, ph_in_raddr1, ph_sc_raddr0, ph_sc_raddr1;
    logic [NP-1:0]    ph_sc_WE, ph_out_WE;
    logic [NP*AW-1:0] ph_sc_waddr, ph_out_waddr;
    logic [NP*DW-1:0] ph_sc_wdata, ph_out_wdata;
    logic [DW-1:0]    ph_in_rdata0, ph_in_rdata1, ph_sc_rdata0, ph_sc_rdata1;
    logic [NP-1:0]    ph_rdata_valid;
    logic [AW-1:0]    final_input_mem_raddr0, final_input_mem_raddr1;
    logic [AW-1:0]    final_scratch_mem_raddr0, final_scratch_mem_raddr1;
    logic [DW-1:0]    final_input_mem_rdata0, final_input_mem_rdata1;
    logic [DW-1:0]    final_scratch_mem_rdata0, final_scratch_mem_rdata1;
    logic             final_scratch_mem_WE, final_output_mem_WE;
    logic [AW-1:0]    final_scratch_mem_waddr, final_output_mem_waddr;
    logic [DW-1:0]    final_scratch_mem_wdata, final_output_mem_wdata;
    logic             input_mem_done, scratch_mem_overflow_fault;
    logic             output_mem_overflow_fault, phase_sel_fault;

    int checks   = 0;
    int failures = 0;

    phase_mem_router #(.NUM_PHASES(NP), .DATA_W(DW), .ADDR_W(AW), .DEPTH_W(DPW)) dut (
        .clock(clock), .reset(reset), .phase_en(phase_en), .image_done_pulse(image_done_pulse),
        .input_mem_depth(input_mem_depth), .scratch_mem_depth(scratch_mem_depth),
        .output_mem_depth(output_mem_depth), .ph_in_rd_en(ph_in_rd_en),
        .ph_in_raddr0(ph_in_raddr0), .ph_in_raddr1(ph_in_raddr1),
        .ph_sc_raddr0(ph_sc_raddr0), .ph_sc_raddr1(ph_sc_raddr1),
        .ph_sc_WE(ph_sc_WE), .ph_sc_waddr(ph_sc_waddr), .ph_sc_wdata(ph_sc_wdata),
        .ph_out_WE(ph_out_WE), .ph_out_waddr(ph_out_waddr), .ph_out_wdata(ph_out_wdata),
        .ph_in_rdata0(ph_in_rdata0), .ph_in_rdata1(ph_in_rdata1),
        .ph_sc_rdata0(ph_sc_rdata0), .ph_sc_rdata1(ph_sc_rdata1),
        .ph_rdata_valid(ph_rdata_valid),
        .final_input_mem_raddr0(final_input_mem_raddr0), .final_input_mem_raddr1(final_input_mem_raddr1),
        .final_scratch_mem_raddr0(final_scratch_mem_raddr0), .final_scratch_mem_raddr1(final_scratch_mem_raddr1),
        .final_input_mem_rdata0(final_input_mem_rdata0), .final_input_mem_rdata1(final_input_mem_rdata1),
        .final_scratch_mem_rdata0(final_scratch_mem_rdata0), .final_scratch_mem_rdata1(final_scratch_mem_rdata1),
        .final_scratch_mem_WE(final_scratch_mem_WE), .final_scratch_mem_waddr(final_scratch_mem_waddr),
        .final_scratch_mem_wdata(final_scratch_mem_wdata),
        .final_output_mem_WE(final_output_mem_WE), .final_output_mem_waddr(final_output_mem_waddr),
        .final_output_mem_wdata(final_output_mem_wdata),
        .input_mem_done(input_mem_done), .scratch_mem_overflow_fault(scratch_mem_overflow_fault),
        .output_mem_overflow_fault(output_mem_overflow_fault), .phase_sel_fault(phase_sel_fault)
    );

    always #5 clock = ~clock;

    // Reference model: mode 0 idle, 1 active, 2 switch; owner as a plain integer.
    bit            m_live = 0;
    int            m_mode, m_owner, m_valid, lo;
    int            m_dep_in, m_dep_sc, m_dep_out, m_cnt;
    bit            m_done, m_sc_f, m_out_f, m_sel_f, m_sc_we, m_out_we;
    int            m_sc_a, m_out_a;
    logic [DW-1:0] m_sc_d, m_out_d;

    always @(posedge clock) begin
        if (reset) begin
            m_live = 1; m_mode = 0; m_owner = 0; m_valid = -1;
            m_dep_in = 0; m_dep_sc = 0; m_dep_out = 0; m_cnt = 0;
            m_done = 0; m_sc_f = 0; m_out_f = 0; m_sel_f = 0;
            m_sc_we = 0; m_out_we = 0; m_sc_a = 0; m_out_a = 0; m_sc_d = '0; m_out_d = '0;
        end else begin
            lo = -1;
            for (int i = NP - 1; i >= 0; i--) if (phase_en[i]) lo = i;
            m_valid  = (m_mode == 1) ? m_owner : -1;
            m_sc_we  = 0;
            m_out_we = 0;
            if (m_mode == 1 && ph_sc_WE[m_owner]) begin
                m_sc_a = int'(ph_sc_waddr[m_owner*AW +: AW]);
                m_sc_d = ph_sc_wdata[m_owner*DW +: DW];
                if (m_sc_a < m_dep_sc) m_sc_we = 1; else m_sc_f = 1;
            end
            if (m_mode == 1 && ph_out_WE[m_owner]) begin
                m_out_a = int'(ph_out_waddr[m_owner*AW +: AW]);
                m_out_d = ph_out_wdata[m_owner*DW +: DW];
                if (m_out_a < m_dep_out) m_out_we = 1; else m_out_f = 1;
            end
            if (m_mode == 1 && ph_in_rd_en[m_owner]) m_cnt = (m_cnt + 2 > CMAX) ? CMAX : m_cnt + 2;
            if (m_mode == 1 && m_cnt >= m_dep_in) m_done = 1;
            if ($countones(phase_en) > 1) m_sel_f = 1;
            if (image_done_pulse) begin
                m_cnt = 0; m_done = 0; m_sc_f = 0; m_out_f = 0; m_sel_f = 0;
            end
            if (m_mode == 0) begin
                m_dep_in  = int'(input_mem_depth);
                m_dep_sc  = int'(scratch_mem_depth);
                m_dep_out = int'(output_mem_depth);
            end
            case (m_mode)
                0: if (lo >= 0) begin m_mode = 1; m_owner = lo; end
                1: if (lo < 0) m_mode = 0; else if (lo != m_owner) m_mode = 2;
                default: if (lo < 0) m_mode = 0; else begin m_mode = 1; m_owner = lo; end
            endcase
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h expected=%0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] exp_ra(input logic [NP*AW-1:0] bus);
        return (m_mode == 1) ? bus[m_owner*AW +: AW] : '0;
    endfunction

    task automatic model_compare();
        chk("in_raddr0", final_input_mem_raddr0, exp_ra(ph_in_raddr0));
        chk("in_raddr1", final_input_mem_raddr1, exp_ra(ph_in_raddr1));
        chk("sc_raddr0", final_scratch_mem_raddr0, exp_ra(ph_sc_raddr0));
        chk("sc_raddr1", final_scratch_mem_raddr1, exp_ra(ph_sc_raddr1));
        chk("rdata_valid", ph_rdata_valid, (m_valid < 0) ? 0 : (64'd1 << m_valid));
        chk("sc_we", final_scratch_mem_WE, m_sc_we);
        chk("out_we", final_output_mem_WE, m_out_we);
        if (m_sc_we) begin
            chk("sc_waddr", final_scratch_mem_waddr, m_sc_a);
            chk("sc_wdata", final_scratch_mem_wdata, m_sc_d);
        end
        if (m_out_we) begin
            chk("out_waddr", final_output_mem_waddr, m_out_a);
            chk("out_wdata", final_output_mem_wdata, m_out_d);
        end
        chk("in_done", input_mem_done, m_done);
        chk("sc_fault", scratch_mem_overflow_fault, m_sc_f);
        chk("out_fault", output_mem_overflow_fault, m_out_f);
        chk("sel_fault", phase_sel_fault, m_sel_f);
        chk("in_rdata0", ph_in_rdata0, final_input_mem_rdata0);
        chk("in_rdata1", ph_in_rdata1, final_input_mem_rdata1);
        chk("sc_rdata0", ph_sc_rdata0, final_scratch_mem_rdata0);
        chk("sc_rdata1", ph_sc_rdata1, final_scratch_mem_rdata1);
    endtask

    always @(negedge clock) begin
        #2;
        if (m_live) model_compare();
    end

    task automatic tick();
        @(negedge clock);
        final_input_mem_rdata0   = $urandom;
        final_input_mem_rdata1   = $urandom;
        final_scratch_mem_rdata0 = $urandom;
        final_scratch_mem_rdata1 = $urandom;
    endtask

    task automatic idle_req();
        ph_in_rd_en = '0; ph_sc_WE = '0; ph_out_WE = '0; image_done_pulse = 1'b0;
    endtask

    task automatic sc_wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
        ph_sc_WE[p] = 1'b1; ph_sc_waddr[p*AW +: AW] = a; ph_sc_wdata[p*DW +: DW] = d;
    endtask

    task automatic out_wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
        ph_out_WE[p] = 1'b1; ph_out_waddr[p*AW +: AW] = a; ph_out_wdata[p*DW +: DW] = d;
    endtask

    initial begin
        reset = 1'b1; phase_en = '0; idle_req();
        input_mem_depth = '0; scratch_mem_depth = '0; output_mem_depth = '0;
        ph_in_raddr0 = {16'h0333, 16'h0222, 16'h0111};
        ph_in_raddr1 = {16'h0334, 16'h0223, 16'h0112};
        ph_sc_raddr0 = {16'h0a33, 16'h0a22, 16'h0a11};
        ph_sc_raddr1 = {16'h0b33, 16'h0b22, 16'h0b11};
        ph_sc_waddr = '0; ph_sc_wdata = '0; ph_out_waddr = '0; ph_out_wdata = '0;
        final_input_mem_rdata0 = '0; final_input_mem_rdata1 = '0;
        final_scratch_mem_rdata0 = '0; final_scratch_mem_rdata1 = '0;
        tick(); tick();
        reset = 1'b0;
        input_mem_depth = 17'd8; scratch_mem_depth = 17'd256; output_mem_depth = 17'd300;
        #2;
        chk("rst_sc_we", final_scratch_mem_WE, 0);
        chk("rst_valid", ph_rdata_valid, 0);
        chk("rst_flags", {input_mem_done, scratch_mem_overflow_fault, output_mem_overflow_fault, phase_sel_fault}, 0);
        chk("rst_raddr", final_input_mem_raddr0, 0);

        // Scratch bounds: 10 lands, 256 (== depth) is dropped.
        tick(); phase_en = 3'b001;
        tick(); sc_wr(0, 16'd10, 32'hA0A0_0010);
        #2 chk("own0_raddr", final_input_mem_raddr0, 16'h0111);
        tick(); idle_req(); sc_wr(0, 16'd256, 32'hDEAD_0100);
        #2 chk("bnd_we", final_scratch_mem_WE, 1);
        chk("bnd_waddr", final_scratch_mem_waddr, 16'd10);
        chk("bnd_wdata", final_scratch_mem_wdata, 32'hA0A0_0010);
        tick(); idle_req();
        #2 chk("bnd_drop", final_scratch_mem_WE, 0);
        chk("bnd_fault", scratch_mem_overflow_fault, 1);

        // Input read progress: depth 8 reached by the fourth owner pulse.
        for (int k = 0; k < 4; k++) begin
            tick(); idle_req(); ph_in_rd_en = (k == 1) ? 3'b011 : 3'b001;
            #2 chk("done_early", input_mem_done, 0);
        end
        tick(); idle_req(); ph_in_rd_en = 3'b001;
        #2 chk("done_rise", input_mem_done, 1);
        tick(); idle_req(); ph_in_rd_en = 3'b001;
        tick(); idle_req();
        #2 chk("done_hold", input_mem_done, 1);

        // Owner change with a phase 0 write captured in the last ACTIVE cycle.
        tick(); idle_req(); phase_en = 3'b010;
        sc_wr(0, 16'd20, 32'h0000_2020); sc_wr(1, 16'd40, 32'h0000_4040);
        #2 chk("sw_last_own", final_input_mem_raddr0, 16'h0111);
        tick(); idle_req(); sc_wr(1, 16'd30, 32'h0000_3030);
        #2 chk("sw_commit_we", final_scratch_mem_WE, 1);
        chk("sw_commit_addr", final_scratch_mem_waddr, 16'd20);
        chk("sw_gap_raddr", final_input_mem_raddr0, 0);
        tick(); idle_req();
        #2 chk("sw_no_new_we", final_scratch_mem_WE, 0);
        chk("sw_new_raddr", final_input_mem_raddr0, 16'h0222);
        chk("sw_valid_gap", ph_rdata_valid, 3'b000);
        tick();
        #2 chk("sw_valid_new", ph_rdata_valid, 3'b010);

        // Multi-hot select: lowest index owns, fault raised.
        tick(); phase_en = 3'b000;
        tick(); phase_en = 3'b011;
        #2 chk("sel_pre", phase_sel_fault, 0);
        tick(); phase_en = 3'b001; out_wr(0, 16'd299, 32'h0000_0299);
        #2 chk("sel_fault", phase_sel_fault, 1);
        chk("sel_owner", final_input_mem_raddr0, 16'h0111);

        // Output bound at depth-1 / depth, then clear racing a new overflow.
        tick(); idle_req(); out_wr(0, 16'd300, 32'h0000_0300);
        #2 chk("out_edge_we", final_output_mem_WE, 1);
        chk("out_edge_addr", final_output_mem_waddr, 16'd299);
        tick(); idle_req(); image_done_pulse = 1'b1; out_wr(0, 16'd500, 32'h0000_0500);
        #2 chk("out_fault_set", output_mem_overflow_fault, 1);
        tick(); idle_req();
        #2 chk("clr_flags", {input_mem_done, scratch_mem_overflow_fault, output_mem_overflow_fault, phase_sel_fault}, 0);

        // Reset while an output write is registered.
        tick(); idle_req(); out_wr(0, 16'd400, 32'h0000_0400);
        tick(); idle_req(); out_wr(0, 16'd5, 32'h0000_0005);
        #2 chk("pre_rst_fault", output_mem_overflow_fault, 1);
        tick(); idle_req(); reset = 1'b1; out_wr(0, 16'd6, 32'h0000_0006);
        #2 chk("pre_rst_we", final_output_mem_WE, 1);
        tick(); idle_req(); reset = 1'b0; phase_en = 3'b000; input_mem_depth = 17'd0;
        #2 chk("post_rst_we", final_output_mem_WE, 0);
        chk("post_rst_flags", {input_mem_done, scratch_mem_overflow_fault, output_mem_overflow_fault, phase_sel_fault}, 0);

        // Zero input depth is done on the first ACTIVE cycle; depths frozen while ACTIVE.
        tick(); phase_en = 3'b001;
        tick(); scratch_mem_depth = 17'd1000; sc_wr(0, 16'd500, 32'h0000_0500);
        #2 chk("zero_pre", input_mem_done, 0);
        tick(); idle_req();
        #2 chk("zero_done", input_mem_done, 1);
        chk("frozen_drop", final_scratch_mem_WE, 0);
        tick();
        #2 chk("frozen_fault", scratch_mem_overflow_fault, 1);
        tick(); tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
